word_assembler64: RTL and testbench

- Byte-to-word front end that sits directly upstream of the 64-bit work/nonce register.
- Collects 8 bytes from the UART receive path into one 64-bit word, then presents it with a load-enable that drives the register's d and en inputs.
- Provides inter-byte timeout resynchronisation, a word counter and sticky error flags for the host status path.

---
 rtl/word_assembler64.sv | 194 +++++++++++++++++++
 tb/tb_word_assembler64.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_assembler64.sv
// ---------------------------------------------------------------------------
// word_assembler64
//   Byte-to-word front end for the 64-bit work/nonce register. Gathers eight
//   received bytes into one 64-bit word and presents it with a load enable
//   (word_out -> register d, word_en -> register en). A partial word that
//   stalls longer than TIMEOUT_CYCLES between bytes is thrown away so the
//   byte stream resynchronises on the next word boundary.
//
//   Optional feature macro: WORD_CHECKSUM_EN
//     When defined, a ninth byte (XOR of the eight data bytes) must follow
//     each word. On a mismatch the word is dropped and chk_err is set.
//     When undefined, chk_err is tied to 0.
//
// Ports
//   clk          system clock, rising edge
//   clr          synchronous active-low reset
//   byte_in      received byte
//   byte_valid   byte_in is valid
//   byte_ready   block accepts a byte this cycle (0 while clr=0)
//   word_out     assembled word
//   word_en      word_out valid, held until word_ready
//   word_ready   downstream takes the word this cycle
//   err_clr      clears the sticky error flags
//   timeout_err  sticky: a partial word was dropped on inter-byte timeout
//   chk_err      sticky: checksum mismatch
//   word_count   words handed downstream, wraps at 16 bits
// ---------------------------------------------------------------------------
module word_assembler64 #(
   parameter bit MSB_FIRST      = 1'b1,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TIMEOUT_W      = 17
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [63:0] word_out,
   output logic        word_en,
   input  logic        word_ready,
   input  logic        err_clr,
   output logic        timeout_err,
   output logic        chk_err,
   output logic [15:0] word_count
);

`ifdef WORD_CHECKSUM_EN
   typedef enum logic [1:0] {S_COLLECT, S_PRESENT, S_CHECK} state_t;
`else
   typedef enum logic [1:0] {S_COLLECT, S_PRESENT} state_t;
`endif

   // Gap value at which an idle cycle drops the partial word.
   localparam logic [TIMEOUT_W-1:0] GAP_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_t                state_q, state_d;
   logic [2:0]            byte_cnt_q, byte_cnt_d;
   logic [TIMEOUT_W-1:0]  gap_q, gap_d;
   logic [63:0]           sr_q, sr_d;
   logic [15:0]           word_count_q, word_count_d;
   logic                  timeout_err_q, timeout_err_d;
   logic                  xfer;
   logic                  gap_run;
   logic                  set_timeout;
`ifdef WORD_CHECKSUM_EN
   logic [7:0]            xor_q, xor_d;
   logic                  chk_err_q, chk_err_d;
   logic                  set_chk;
`endif

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      gap_d        = gap_q;
      sr_d         = sr_q;
      word_count_d = word_count_q;
      gap_run      = 1'b0;
      set_timeout  = 1'b0;
`ifdef WORD_CHECKSUM_EN
      xor_d        = xor_q;
      set_chk      = 1'b0;
      byte_ready   = clr & ((state_q == S_COLLECT) | (state_q == S_CHECK));
`else
      byte_ready   = clr & (state_q == S_COLLECT);
`endif
      xfer = byte_valid & byte_ready;

      case (state_q)
         S_COLLECT: begin
            if (xfer) begin
               sr_d       = MSB_FIRST ? {sr_q[55:0], byte_in} : {byte_in, sr_q[63:8]};
               byte_cnt_d = byte_cnt_q + 3'd1;
               gap_d      = '0;
`ifdef WORD_CHECKSUM_EN
               // First byte of a word restarts the running XOR.
               xor_d = (byte_cnt_q == 3'd0) ? byte_in : (xor_q ^ byte_in);
`endif
               if (byte_cnt_q == 3'd7) begin
                  byte_cnt_d = 3'd0;
`ifdef WORD_CHECKSUM_EN
                  state_d    = S_CHECK;
`else
                  state_d    = S_PRESENT;
`endif
               end
            end else if (byte_cnt_q != 3'd0) begin
               gap_run = 1'b1;
            end else begin
               gap_d = '0;
            end
         end
`ifdef WORD_CHECKSUM_EN
         S_CHECK: begin
            if (xfer) begin
               gap_d = '0;
               if (byte_in == xor_q) begin
                  state_d = S_PRESENT;
               end else begin
                  set_chk = 1'b1;
                  state_d = S_COLLECT;
               end
            end else begin
               gap_run = 1'b1;
            end
         end
`endif
         S_PRESENT: begin
            // Downstream stall never times out: gap timer parked at 0.
            gap_d = '0;
            if (word_ready) begin
               word_count_d = word_count_q + 16'd1;
               byte_cnt_d   = 3'd0;
               state_d      = S_COLLECT;
            end
         end
         default: state_d = S_COLLECT;
      endcase

      // Idle cycle inside a partial word (or while awaiting the checksum).
      if (gap_run) begin
         if (gap_q == GAP_LAST) begin
            byte_cnt_d  = 3'd0;
            gap_d       = '0;
            set_timeout = 1'b1;
            state_d     = S_COLLECT;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      end

      // Set beats clear when both happen in the same cycle.
      timeout_err_d = set_timeout | (timeout_err_q & ~err_clr);
`ifdef WORD_CHECKSUM_EN
      chk_err_d     = set_chk | (chk_err_q & ~err_clr);
`endif
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q       <= S_COLLECT;
         byte_cnt_q    <= '0;
         gap_q         <= '0;
         sr_q          <= '0;
         word_count_q  <= '0;
         timeout_err_q <= 1'b0;
`ifdef WORD_CHECKSUM_EN
         xor_q         <= '0;
         chk_err_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         gap_q         <= gap_d;
         sr_q          <= sr_d;
         word_count_q  <= word_count_d;
         timeout_err_q <= timeout_err_d;
`ifdef WORD_CHECKSUM_EN
         xor_q         <= xor_d;
         chk_err_q     <= chk_err_d;
`endif
      end
   end

   assign word_out    = sr_q;
   assign word_en     = (state_q == S_PRESENT);
   assign timeout_err = timeout_err_q;
   assign word_count  = word_count_q;
`ifdef WORD_CHECKSUM_EN
   assign chk_err     = chk_err_q;
`else
   assign chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_word_assembler64.sv
// ---------------------------------------------------------------------------
// tb_word_assembler64
//   Drives two instances (MSB-first and LSB-first) from the same byte stream
//   and compares both against a transaction-level model: a queue of pending
//   bytes, a "word on offer" flag, an idle counter and the sticky flags.
// ---------------------------------------------------------------------------
module tb_word_assembler64;

   localparam int TO = 10;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [7:0]  byte_in = '0;
   logic        byte_valid = 1'b0;
   logic        word_ready = 1'b0;
   logic        err_clr = 1'b0;

   logic        rdy_m, en_m, te_m, ce_m;
   logic [63:0] wo_m;
   logic [15:0] wc_m;
   logic        rdy_l, en_l, te_l, ce_l;
   logic [63:0] wo_l;
   logic [15:0] wc_l;

   word_assembler64 #(.MSB_FIRST(1'b1), .TIMEOUT_CYCLES(TO), .TIMEOUT_W(4)) u_msb (
      .clk(clk), .clr(clr), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(rdy_m), .word_out(wo_m), .word_en(en_m), .word_ready(word_ready),
      .err_clr(err_clr), .timeout_err(te_m), .chk_err(ce_m), .word_count(wc_m));

   word_assembler64 #(.MSB_FIRST(1'b0), .TIMEOUT_CYCLES(TO), .TIMEOUT_W(4)) u_lsb (
      .clk(clk), .clr(clr), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(rdy_l), .word_out(wo_l), .word_en(en_l), .word_ready(word_ready),
      .err_clr(err_clr), .timeout_err(te_l), .chk_err(ce_l), .word_count(wc_l));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0]  m_q[$];      // bytes of the partial word, in arrival order
   bit          m_pres;      // word on offer downstream
   bit          m_chk;       // awaiting checksum byte
   logic [63:0] m_wm, m_wl;  // word as seen by MSB-first / LSB-first build
   logic [7:0]  m_ck;        // expected checksum
   int          m_idle;      // idle cycles since last byte of partial word
   bit          m_te, m_ce;
   logic [15:0] m_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit exp_rdy;
      exp_rdy = clr && !m_pres;
      chk("byte_ready_m", {63'd0, rdy_m}, {63'd0, exp_rdy});
      chk("byte_ready_l", {63'd0, rdy_l}, {63'd0, exp_rdy});
      chk("word_en_m", {63'd0, en_m}, {63'd0, m_pres});
      chk("word_en_l", {63'd0, en_l}, {63'd0, m_pres});
      chk("timeout_err_m", {63'd0, te_m}, {63'd0, m_te});
      chk("timeout_err_l", {63'd0, te_l}, {63'd0, m_te});
      chk("chk_err_m", {63'd0, ce_m}, {63'd0, m_ce});
      chk("chk_err_l", {63'd0, ce_l}, {63'd0, m_ce});
      chk("word_count_m", {48'd0, wc_m}, {48'd0, m_cnt});
      chk("word_count_l", {48'd0, wc_l}, {48'd0, m_cnt});
      if (m_pres) begin
         chk("word_out_m", wo_m, m_wm);
         chk("word_out_l", wo_l, m_wl);
      end
   endtask

   task automatic do_reset();
      clr = 1'b0; byte_valid = 1'b0; word_ready = 1'b0; err_clr = 1'b0;
      @(posedge clk); #1;
      m_q.delete(); m_pres = 0; m_chk = 0; m_idle = 0;
      m_te = 0; m_ce = 0; m_cnt = '0;
      check_all();
      chk("reset_word_out_m", wo_m, 64'd0);
      chk("reset_word_out_l", wo_l, 64'd0);
      clr = 1'b1;
   endtask

   // Partial word goes idle: count toward the timeout, dropping it at the limit.
   task automatic model_idle(output bit st);
      st = 0;
      if (m_idle == TO - 1) begin
         m_q.delete(); m_chk = 0; m_idle = 0; st = 1;
      end else begin
         m_idle++;
      end
   endtask

   task automatic step(input bit v, input logic [7:0] b, input bit wr, input bit ec);
      bit xfer, st, sc;
      byte_valid = v; byte_in = b; word_ready = wr; err_clr = ec;
      xfer = v && !m_pres;
      st = 0; sc = 0;
      if (m_pres) begin
         if (wr) begin m_pres = 0; m_cnt = m_cnt + 16'd1; end
      end else if (m_chk) begin
         if (xfer) begin
            m_chk = 0; m_idle = 0;
            if (b == m_ck) m_pres = 1; else sc = 1;
         end else model_idle(st);
      end else if (xfer) begin
         m_q.push_back(b);
         m_idle = 0;
         if (m_q.size() == 8) begin
            m_wm = '0; m_wl = '0; m_ck = '0;
            for (int i = 0; i < 8; i++) begin
               m_wm[8*(7-i) +: 8] = m_q[i];
               m_wl[8*i +: 8]     = m_q[i];
               m_ck               = m_ck ^ m_q[i];
            end
            m_q.delete();
`ifdef WORD_CHECKSUM_EN
            m_chk = 1;
`else
            m_pres = 1;
`endif
         end
      end else if (m_q.size() != 0) begin
         model_idle(st);
      end
      m_te = st | (m_te & !ec);
`ifdef WORD_CHECKSUM_EN
      m_ce = sc | (m_ce & !ec);
`else
      m_ce = 0;
`endif
      @(posedge clk); #1;
      check_all();
   endtask

   // Eight bytes base, base+1, ... then (with the macro) the checksum byte.
   task automatic send_word(input logic [7:0] base, input bit wr, input bit good_ck);
      logic [7:0] x;
      x = '0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, base + 8'(i), wr, 1'b0);
         x = x ^ (base + 8'(i));
      end
`ifdef WORD_CHECKSUM_EN
      step(1'b1, good_ck ? x : ~x, wr, 1'b0);
`else
      if (!good_ck) x = ~x;
`endif
   endtask

   initial begin
      int pv;
      do_reset();

      // Back-to-back word, downstream always ready.
      send_word(8'h01, 1'b1, 1'b1);
      chk("first_en", {63'd0, en_m}, 64'd1);
      chk("first_word_msb", wo_m, 64'h0102030405060708);
      chk("first_word_lsb", wo_l, 64'h0807060504030201);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("first_en_one_cycle", {63'd0, en_m}, 64'd0);
      chk("first_count", {48'd0, wc_m}, 64'd1);

      // Downstream stall for 20 cycles with an offered byte that must be refused.
      send_word(8'h40, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      chk("stall_word_msb", wo_m, 64'h4041424344454647);
      chk("stall_no_timeout", {63'd0, te_m}, 64'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Timeout after 3 bytes and TO idle cycles, then recovery.
      for (int i = 0; i < 3; i++) step(1'b1, 8'h11 + 8'(i), 1'b1, 1'b0);
      for (int i = 0; i < TO; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("timeout_set", {63'd0, te_m}, 64'd1);
      send_word(8'hAA, 1'b1, 1'b1);
      chk("after_timeout_msb", wo_m, 64'hAAABACADAEAFB0B1);
      chk("after_timeout_lsb", wo_l, 64'hB1B0AFAEADACABAA);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("err_clr", {63'd0, te_m}, 64'd0);

      // A byte arriving on the last allowed idle cycle is accepted.
      for (int i = 0; i < 2; i++) step(1'b1, 8'h21 + 8'(i), 1'b1, 1'b0);
      for (int i = 0; i < TO - 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h23, 1'b1, 1'b0);
      chk("edge_byte_no_timeout", {63'd0, te_m}, 64'd0);
      for (int i = 0; i < 5; i++) step(1'b1, 8'h24 + 8'(i), 1'b1, 1'b0);
`ifdef WORD_CHECKSUM_EN
      step(1'b1, 8'h21 ^ 8'h22 ^ 8'h23 ^ 8'h24 ^ 8'h25 ^ 8'h26 ^ 8'h27 ^ 8'h28, 1'b1, 1'b0);
`endif
      chk("edge_word_msb", wo_m, 64'h2122232425262728);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Timeout set in the same cycle as err_clr: set wins.
      for (int i = 0; i < 3; i++) step(1'b1, 8'h31, 1'b1, 1'b0);
      for (int i = 0; i < TO - 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("set_beats_clear", {63'd0, te_m}, 64'd1);
      step(1'b0, 8'h00, 1'b1, 1'b1);

`ifdef WORD_CHECKSUM_EN
      // Bad checksum drops the word.
      send_word(8'h01, 1'b1, 1'b0);
      chk("bad_ck_no_en", {63'd0, en_m}, 64'd0);
      chk("bad_ck_flag", {63'd0, ce_m}, 64'd1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
`endif

      // Randomised traffic in phases of differing byte density.
      for (int ph = 0; ph < 30; ph++) begin
         case ($urandom_range(2))
            0:       pv = 95;
            1:       pv = 50;
            default: pv = 4;
         endcase
         for (int i = 0; i < 60; i++)
            step(($urandom % 100) < pv, 8'($urandom), ($urandom % 4) != 0,
                 ($urandom % 40) == 0);
      end

      // Reset mid-word loses the partial word.
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 8'hE0 + 8'(i), 1'b1, 1'b0);
      do_reset();
      send_word(8'h51, 1'b1, 1'b1);
      chk("post_reset_word_msb", wo_m, 64'h5152535455565758);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_reset_count", {48'd0, wc_m}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
